seq_packet_job_scheduler: RTL and testbench

Central job-order scheduler for the sequence-packet output path. It records the order in which jobs are dispatched to the match engines. It grants the shared output sequence-packet stream to one engine at a time in exactly that order, and holds the grant until that engine's end-of-job (eoj) beat is accepted. It sits between the per-engine sequence-packet outputs and the downstream sequence encoder, as a centralised alternative to the token-ring bus.

---
 rtl/seq_packet_job_scheduler_pkg.sv | 24 ++
 rtl/seq_packet_job_scheduler_if.sv | 54 +++++
 rtl/seq_packet_job_scheduler_order_fifo.sv | 67 ++++++
 rtl/seq_packet_job_scheduler.sv | 140 ++++++++++++++
 tb/tb_seq_packet_job_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_packet_job_scheduler_pkg.sv
// Shared definitions for the sequence-packet job scheduler.
// - SEQ_*_W : widths of one engine's sequence-packet fields.
// - sched_state_e : grant FSM states.
// - id_width() : engine-index width, at least one bit.
package seq_packet_job_scheduler_pkg;

  localparam int SEQ_STRB_W    = 4;
  localparam int SEQ_LL_W      = 8;
  localparam int SEQ_ML_W      = 8;
  localparam int SEQ_OFFSET_W  = 16;
  localparam int SEQ_OVERLAP_W = 1;
  localparam int SEQ_EOJ_W     = 1;
  localparam int SEQ_DELIM_W   = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_packet_job_scheduler_if.sv
// Bundle of the scheduler's dispatch, engine, output and status signals.
// - slave  : scheduler side. It drives o_* and receives i_*.
// - master : environment side. It drives i_* and receives o_*.
// Engine k's fields occupy slice k of every i_eng_* vector.
interface seq_packet_job_scheduler_if
  import seq_packet_job_scheduler_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int ORDER_DEPTH = 8
);
  localparam int ID_W  = id_width(NUM_ENGINES);
  localparam int CNT_W = $clog2(ORDER_DEPTH + 1);

  logic                                 i_dispatch_valid;
  logic [ID_W-1:0]                      i_dispatch_id;
  logic                                 o_dispatch_ready;
  logic [NUM_ENGINES-1:0]               i_eng_valid;
  logic [NUM_ENGINES*SEQ_STRB_W-1:0]    i_eng_strb;
  logic [NUM_ENGINES*SEQ_LL_W-1:0]      i_eng_ll;
  logic [NUM_ENGINES*SEQ_ML_W-1:0]      i_eng_ml;
  logic [NUM_ENGINES*SEQ_OFFSET_W-1:0]  i_eng_offset;
  logic [NUM_ENGINES*SEQ_OVERLAP_W-1:0] i_eng_overlap;
  logic [NUM_ENGINES*SEQ_EOJ_W-1:0]     i_eng_eoj;
  logic [NUM_ENGINES*SEQ_DELIM_W-1:0]   i_eng_delim;
  logic [NUM_ENGINES-1:0]               o_eng_ready;
  logic                                 o_next_valid;
  logic [SEQ_STRB_W-1:0]                o_next_strb;
  logic [SEQ_LL_W-1:0]                  o_next_ll;
  logic [SEQ_ML_W-1:0]                  o_next_ml;
  logic [SEQ_OFFSET_W-1:0]              o_next_offset;
  logic [SEQ_OVERLAP_W-1:0]             o_next_overlap;
  logic [SEQ_EOJ_W-1:0]                 o_next_eoj;
  logic [SEQ_DELIM_W-1:0]               o_next_delim;
  logic                                 i_next_ready;
  logic [CNT_W-1:0]                     o_pending;
  logic                                 o_busy;
  logic                                 o_err_bad_id;

  modport slave (
    input  i_dispatch_valid, i_dispatch_id, i_eng_valid, i_eng_strb, i_eng_ll,
           i_eng_ml, i_eng_offset, i_eng_overlap, i_eng_eoj, i_eng_delim, i_next_ready,
    output o_dispatch_ready, o_eng_ready, o_next_valid, o_next_strb, o_next_ll,
           o_next_ml, o_next_offset, o_next_overlap, o_next_eoj, o_next_delim,
           o_pending, o_busy, o_err_bad_id
  );

  modport master (
    output i_dispatch_valid, i_dispatch_id, i_eng_valid, i_eng_strb, i_eng_ll,
           i_eng_ml, i_eng_offset, i_eng_overlap, i_eng_eoj, i_eng_delim, i_next_ready,
    input  o_dispatch_ready, o_eng_ready, o_next_valid, o_next_strb, o_next_ll,
           o_next_ml, o_next_offset, o_next_overlap, o_next_eoj, o_next_delim,
           o_pending, o_busy, o_err_bad_id
  );
endinterface

// File: rtl/seq_packet_job_scheduler_order_fifo.sv
// seq_order_fifo: synchronous FIFO of engine ids, in dispatch order.
// Ports:
// - clk, rst           : clock and asynchronous active-high reset.
// - push, push_data    : enqueue. Ignored when full.
// - pop, pop_data      : dequeue. pop_data shows the head combinationally.
//                        pop is ignored when empty.
// - full, empty, count : occupancy status.
module seq_order_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage write. It has no reset because stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/seq_packet_job_scheduler.sv
// seq_packet_job_scheduler: grants the shared sequence-packet output to one
// match engine at a time, in dispatch order. A grant ends on its accepted eoj beat.
// Ports:
// - clk, rst : clock and asynchronous active-high reset.
// - bus      : slave view of seq_packet_job_scheduler_if. It carries dispatch
//              in/ready, per-engine packets and readies, the output packet
//              stream, and the pending/busy/bad-id status.
module seq_packet_job_scheduler
  import seq_packet_job_scheduler_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  seq_packet_job_scheduler_if.slave bus
);
  localparam int                ID_W      = id_width(NUM_ENGINES);
  localparam int                CNT_W     = $clog2(ORDER_DEPTH + 1);
  localparam logic [ID_W:0]     NUM_ENG_L = (ID_W + 1)'(NUM_ENGINES);

  sched_state_e              state_r, state_nxt_s;
  logic [ID_W-1:0]           grant_id_r, grant_id_nxt_s, head_s;
  logic                      err_r;
  logic                      full_s, empty_s, id_ok_s, disp_take_s, push_s, bad_s;
  logic                      idle_s, bypass_s, fifo_push_s, pop_s, grant_load_s, eoj_beat_s;
  logic [CNT_W-1:0]          count_s;
  logic [NUM_ENGINES-1:0]    sel_s, eng_ready_s;
  logic                      next_valid_s;
  logic [SEQ_STRB_W-1:0]     next_strb_s;
  logic [SEQ_LL_W-1:0]       next_ll_s;
  logic [SEQ_ML_W-1:0]       next_ml_s;
  logic [SEQ_OFFSET_W-1:0]   next_offset_s;
  logic [SEQ_OVERLAP_W-1:0]  next_overlap_s;
  logic [SEQ_EOJ_W-1:0]      next_eoj_s;
  logic [SEQ_DELIM_W-1:0]    next_delim_s;

  // A dispatch is consumed whenever the queue has room. Only in-range ids are stored.
  assign id_ok_s     = ({1'b0, bus.i_dispatch_id} < NUM_ENG_L);
  assign disp_take_s = bus.i_dispatch_valid && !full_s;
  assign push_s      = disp_take_s && id_ok_s;
  assign bad_s       = disp_take_s && !id_ok_s;

  // When idle with nothing queued, a dispatch goes straight into the grant
  // register. The grant is then visible in the cycle after the dispatch.
  assign idle_s         = (state_r == ST_IDLE);
  assign bypass_s       = idle_s && empty_s && push_s;
  assign fifo_push_s    = push_s && !bypass_s;
  assign eoj_beat_s     = next_valid_s && bus.i_next_ready && (|next_eoj_s);
  assign pop_s          = !empty_s && (idle_s || eoj_beat_s);
  assign grant_load_s   = pop_s || bypass_s;
  assign grant_id_nxt_s = pop_s ? head_s : bus.i_dispatch_id;

  seq_order_fifo #(
    .WIDTH (ID_W),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (bus.i_dispatch_id),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Grant FSM next state. An eoj with an empty queue releases the grant.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = grant_load_s ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_nxt_s = (eoj_beat_s && empty_s) ? ST_IDLE : ST_GRANT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, grant id and the sticky bad-id flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      grant_id_r <= ID_W'(0);
      err_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_load_s) begin
        grant_id_r <= grant_id_nxt_s;
      end
      err_r <= err_r | bad_s;
    end
  end

  // One-hot engine select. It is all zero while idle.
  always_comb begin
    sel_s = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      sel_s[k] = (state_r == ST_GRANT) && (grant_id_r == ID_W'(k));
    end
  end

  // AND-OR output mux. The outputs are zero while idle.
  always_comb begin
    next_valid_s   = 1'b0;
    next_strb_s    = '0;
    next_ll_s      = '0;
    next_ml_s      = '0;
    next_offset_s  = '0;
    next_overlap_s = '0;
    next_eoj_s     = '0;
    next_delim_s   = '0;
    eng_ready_s    = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      next_valid_s   = next_valid_s   | (sel_s[k] & bus.i_eng_valid[k]);
      next_strb_s    = next_strb_s    | ({SEQ_STRB_W{sel_s[k]}}    & bus.i_eng_strb[k*SEQ_STRB_W +: SEQ_STRB_W]);
      next_ll_s      = next_ll_s      | ({SEQ_LL_W{sel_s[k]}}      & bus.i_eng_ll[k*SEQ_LL_W +: SEQ_LL_W]);
      next_ml_s      = next_ml_s      | ({SEQ_ML_W{sel_s[k]}}      & bus.i_eng_ml[k*SEQ_ML_W +: SEQ_ML_W]);
      next_offset_s  = next_offset_s  | ({SEQ_OFFSET_W{sel_s[k]}}  & bus.i_eng_offset[k*SEQ_OFFSET_W +: SEQ_OFFSET_W]);
      next_overlap_s = next_overlap_s | ({SEQ_OVERLAP_W{sel_s[k]}} & bus.i_eng_overlap[k*SEQ_OVERLAP_W +: SEQ_OVERLAP_W]);
      next_eoj_s     = next_eoj_s     | ({SEQ_EOJ_W{sel_s[k]}}     & bus.i_eng_eoj[k*SEQ_EOJ_W +: SEQ_EOJ_W]);
      next_delim_s   = next_delim_s   | ({SEQ_DELIM_W{sel_s[k]}}   & bus.i_eng_delim[k*SEQ_DELIM_W +: SEQ_DELIM_W]);
      eng_ready_s[k] = sel_s[k] & bus.i_next_ready;
    end
  end

  assign bus.o_dispatch_ready = !full_s;
  assign bus.o_eng_ready      = eng_ready_s;
  assign bus.o_next_valid     = next_valid_s;
  assign bus.o_next_strb      = next_strb_s;
  assign bus.o_next_ll        = next_ll_s;
  assign bus.o_next_ml        = next_ml_s;
  assign bus.o_next_offset    = next_offset_s;
  assign bus.o_next_overlap   = next_overlap_s;
  assign bus.o_next_eoj       = next_eoj_s;
  assign bus.o_next_delim     = next_delim_s;
  assign bus.o_pending        = count_s;
  assign bus.o_busy           = (state_r == ST_GRANT);
  assign bus.o_err_bad_id     = err_r;

endmodule

// File: tb/tb_seq_packet_job_scheduler.sv
// Directed bench for seq_packet_job_scheduler.
// Each engine model sends 3-beat jobs. Beat b of engine k carries
// ll = {k, b}, offset = {k, b} and eoj on b == 2. The model advances
// only when the engine's beat is accepted.
// With 4 engines, a 2-bit id can never be out of range. The bad-id
// behaviour is therefore exercised on a second, 3-engine instance.
module tb_seq_packet_job_scheduler;
  import seq_packet_job_scheduler_pkg::*;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  int   beat [4];
  logic [3:0] eng_en;
  logic [7:0] exp_ll [9];

  seq_packet_job_scheduler_if #(.NUM_ENGINES(4), .ORDER_DEPTH(8)) bus  ();
  seq_packet_job_scheduler_if #(.NUM_ENGINES(3), .ORDER_DEPTH(4)) bus3 ();

  seq_packet_job_scheduler #(.NUM_ENGINES(4), .ORDER_DEPTH(8)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  seq_packet_job_scheduler #(.NUM_ENGINES(3), .ORDER_DEPTH(4)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive_engines();
    for (int k = 0; k < 4; k++) begin
      bus.i_eng_valid[k]                                 = eng_en[k];
      bus.i_eng_strb[k*SEQ_STRB_W +: SEQ_STRB_W]         = 4'hF;
      bus.i_eng_ll[k*SEQ_LL_W +: SEQ_LL_W]               = {4'(k), 4'(beat[k])};
      bus.i_eng_ml[k*SEQ_ML_W +: SEQ_ML_W]               = 8'(k);
      bus.i_eng_offset[k*SEQ_OFFSET_W +: SEQ_OFFSET_W]   = {8'(k), 8'(beat[k])};
      bus.i_eng_overlap[k*SEQ_OVERLAP_W +: SEQ_OVERLAP_W] = 1'b0;
      bus.i_eng_eoj[k*SEQ_EOJ_W +: SEQ_EOJ_W]            = SEQ_EOJ_W'(beat[k] == 2);
      bus.i_eng_delim[k*SEQ_DELIM_W +: SEQ_DELIM_W]      = 1'b0;
    end
  endtask

  // Sample the handshakes before the edge, then advance the engine models after it.
  task automatic tick();
    logic [3:0] fire;
    fire = bus.o_eng_ready & bus.i_eng_valid;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (fire[k]) beat[k] = (beat[k] == 2) ? 0 : beat[k] + 1;
    end
    drive_engines();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_ll = '{8'h20, 8'h21, 8'h22, 8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
    for (int k = 0; k < 4; k++) beat[k] = 0;
    eng_en = 4'h0;
    rst = 1'b1;
    bus.i_dispatch_valid  = 1'b0;
    bus.i_dispatch_id     = 2'd0;
    bus.i_next_ready      = 1'b0;
    drive_engines();
    bus3.i_dispatch_valid = 1'b0;
    bus3.i_dispatch_id    = 2'd0;
    bus3.i_next_ready     = 1'b1;
    bus3.i_eng_valid      = '0;
    bus3.i_eng_strb       = '0;
    bus3.i_eng_ll         = '0;
    bus3.i_eng_ml         = '0;
    bus3.i_eng_offset     = '0;
    bus3.i_eng_overlap    = '0;
    bus3.i_eng_eoj        = '0;
    bus3.i_eng_delim      = '0;
    #2;
    chk("rst_next_valid", 32'(bus.o_next_valid), 32'd0);
    chk("rst_eng_ready", 32'(bus.o_eng_ready), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_pending", 32'(bus.o_pending), 32'd0);
    chk("rst_err", 32'(bus.o_err_bad_id), 32'd0);
    chk("rst_dispatch_ready", 32'(bus.o_dispatch_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // Bad id on the 3-engine instance: flagged, not queued, and later ids still schedule.
    bus3.i_dispatch_valid = 1'b1;
    bus3.i_dispatch_id    = 2'd3;
    tick();
    bus3.i_dispatch_id    = 2'd2;
    #1;
    chk("bad_err_set", 32'(bus3.o_err_bad_id), 32'd1);
    chk("bad_pending", 32'(bus3.o_pending), 32'd0);
    chk("bad_not_busy", 32'(bus3.o_busy), 32'd0);
    tick();
    bus3.i_dispatch_valid = 1'b0;
    #1;
    chk("bad_then_grant", 32'(bus3.o_busy), 32'd1);
    chk("bad_then_ready", 32'(bus3.o_eng_ready), 32'h4);
    tick();
    #1;
    chk("bad_err_sticky", 32'(bus3.o_err_bad_id), 32'd1);

    // Jobs 2,0,1, with all engines valid: 9 beats back to back, in dispatch order.
    eng_en = 4'hF;
    drive_engines();
    bus.i_next_ready     = 1'b1;
    bus.i_dispatch_valid = 1'b1;
    bus.i_dispatch_id    = 2'd2;
    tick();
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("order_valid", 32'(bus.o_next_valid), 32'd1);
      chk("order_ll", 32'(bus.o_next_ll), 32'(exp_ll[i]));
      chk("order_eoj", 32'(bus.o_next_eoj), 32'(i % 3 == 2));
      if (i == 4) chk("order_offset", 32'(bus.o_next_offset), 32'h0001);
      if (i == 0) bus.i_dispatch_id = 2'd0;
      else if (i == 1) bus.i_dispatch_id = 2'd1;
      else bus.i_dispatch_valid = 1'b0;
      tick();
    end
    #1;
    chk("order_idle_busy", 32'(bus.o_busy), 32'd0);
    chk("order_idle_valid", 32'(bus.o_next_valid), 32'd0);

    // Ready stalls on the eoj beat: the grant holds until that eoj is accepted.
    bus.i_dispatch_valid = 1'b1;
    bus.i_dispatch_id    = 2'd3;
    #1;
    chk("stall_pre_busy", 32'(bus.o_busy), 32'd0);
    tick();
    bus.i_dispatch_id = 2'd0;
    #1;
    chk("stall_first_ll", 32'(bus.o_next_ll), 32'h30);
    chk("stall_busy", 32'(bus.o_busy), 32'd1);
    tick();
    bus.i_dispatch_valid = 1'b0;
    #1;
    chk("stall_second_ll", 32'(bus.o_next_ll), 32'h31);
    chk("stall_pending", 32'(bus.o_pending), 32'd1);
    chk("other_engine_not_ready", 32'(bus.o_eng_ready), 32'h8);
    tick();
    bus.i_next_ready = 1'b0;
    #1;
    chk("stall_eoj_ll", 32'(bus.o_next_ll), 32'h32);
    chk("stall_eoj_flag", 32'(bus.o_next_eoj), 32'd1);
    chk("stall_ready_low", 32'(bus.o_eng_ready), 32'h0);
    tick();
    #1;
    chk("stall_hold_ll", 32'(bus.o_next_ll), 32'h32);
    chk("stall_hold_pending", 32'(bus.o_pending), 32'd1);
    bus.i_next_ready = 1'b1;
    #1;
    chk("stall_ready_high", 32'(bus.o_eng_ready), 32'h8);
    tick();
    #1;
    chk("switch_ll", 32'(bus.o_next_ll), 32'h00);
    chk("switch_ready", 32'(bus.o_eng_ready), 32'h1);
    chk("switch_pending", 32'(bus.o_pending), 32'd0);
    tick();
    tick();
    tick();
    #1;
    chk("stall_end_busy", 32'(bus.o_busy), 32'd0);
    chk("stall_end_ll", 32'(bus.o_next_ll), 32'h00);

    // Fill: the first dispatch is granted and the next 8 fill the queue.
    // A further dispatch waits for a pop.
    eng_en = 4'h0;
    drive_engines();
    bus.i_dispatch_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.i_dispatch_id = 2'(i);
      tick();
    end
    bus.i_dispatch_id = 2'd1;
    #1;
    chk("full_pending", 32'(bus.o_pending), 32'd8);
    chk("full_not_ready", 32'(bus.o_dispatch_ready), 32'd0);
    chk("full_busy", 32'(bus.o_busy), 32'd1);
    tick();
    #1;
    chk("full_refused", 32'(bus.o_pending), 32'd8);
    eng_en = 4'b0001;
    drive_engines();
    tick();
    tick();
    #1;
    chk("full_pre_eoj", 32'(bus.o_pending), 32'd8);
    tick();
    #1;
    chk("full_after_pop", 32'(bus.o_pending), 32'd7);
    chk("full_ready_again", 32'(bus.o_dispatch_ready), 32'd1);
    chk("full_next_grant_idle_eng", 32'(bus.o_next_valid), 32'd0);
    tick();
    bus.i_dispatch_valid = 1'b0;
    #1;
    chk("full_accepted", 32'(bus.o_pending), 32'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset mid-job with 3 jobs queued. Then a fresh dispatch of id 0 is granted.
    eng_en = 4'hF;
    drive_engines();
    bus.i_next_ready     = 1'b0;
    bus.i_dispatch_valid = 1'b1;
    bus.i_dispatch_id    = 2'd1;
    tick();
    bus.i_dispatch_id = 2'd2;
    tick();
    bus.i_dispatch_id = 2'd3;
    tick();
    bus.i_dispatch_id = 2'd0;
    tick();
    bus.i_dispatch_valid = 1'b0;
    #1;
    chk("mid_pending", 32'(bus.o_pending), 32'd3);
    chk("mid_busy", 32'(bus.o_busy), 32'd1);
    bus.i_next_ready = 1'b1;
    #1;
    chk("mid_first_ll", 32'(bus.o_next_ll), 32'h10);
    tick();
    #1;
    chk("mid_second_ll", 32'(bus.o_next_ll), 32'h11);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.o_next_valid), 32'd0);
    chk("mid_rst_eng_ready", 32'(bus.o_eng_ready), 32'd0);
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("mid_rst_pending", 32'(bus.o_pending), 32'd0);
    chk("mid_rst_err", 32'(bus.o_err_bad_id), 32'd0);
    chk("mid_rst_dready", 32'(bus.o_dispatch_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("post_rst_quiet_valid", 32'(bus.o_next_valid), 32'd0);
    chk("post_rst_quiet_busy", 32'(bus.o_busy), 32'd0);
    bus.i_dispatch_valid = 1'b1;
    bus.i_dispatch_id    = 2'd0;
    tick();
    bus.i_dispatch_valid = 1'b0;
    #1;
    chk("post_rst_grant_busy", 32'(bus.o_busy), 32'd1);
    chk("post_rst_grant_ready", 32'(bus.o_eng_ready), 32'h1);
    chk("post_rst_grant_ll", 32'(bus.o_next_ll), 32'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
